sobol_multi_gen: RTL

//  Parametrised multi-dimensional Sobol quasi-random generator feeding path generation in the option-pricing engine.

---
 rtl/sobol_pkg.sv | 15 +
 rtl/ufix_to_fp16.sv | 41 ++++
 rtl/sobol_multi_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared types and FP16 constants for the Sobol point generator
package sobol_pkg;

    // Run control: IDLE waits for start, RUN presents points, DONE emits the done pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sobol_state_t;

    localparam int          FP16_BIAS   = 15;
    localparam int          FP16_MANT_W = 10;
    localparam logic [15:0] FP16_ZERO   = 16'h0000;

endpackage

// File: rtl/ufix_to_fp16.sv
// rtl/ufix_to_fp16.sv - unsigned fraction x * 2^-BITS to FP16, truncating, sign always 0
//
// Ports:
//   x   in  BITS  fixed-point fraction in [0,1)
//   fp  out 16    FP16 encoding of x (combinational)
module ufix_to_fp16
    import sobol_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] x,
    output logic [15:0]     fp
);

    logic [BITS-1:0] norm;
    int              p;
    int              e;

    always_comb begin
        // Priority encoder: highest set bit wins because later iterations overwrite.
        p = 0;
        for (int k = 0; k < BITS; k++) begin
            if (x[k]) begin
                p = k;
            end
        end
        e    = p - BITS + FP16_BIAS;
        // Move the leading one to bit BITS-1; the mantissa is the field just below it.
        norm = x << (BITS - 1 - p);
        fp   = FP16_ZERO;
        if (x == '0) begin
            fp = FP16_ZERO;
        end else if (p >= BITS - 14) begin
            fp = {1'b0, 5'(e), FP16_MANT_W'(norm >> (BITS - 1 - FP16_MANT_W))};
        end else begin
            // Subnormal: mantissa counts units of 2^-24, so only a fixed shift is needed.
            fp = {1'b0, 5'd0, FP16_MANT_W'(x << (24 - BITS))};
        end
    end

endmodule

// File: rtl/sobol_multi_gen.sv
// rtl/sobol_multi_gen.sv - multi-dimensional Sobol generator, Gray-code update, FP16 output stream
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, num_points      begin a run of num_points points (IDLE only)
//   abort                  drop the run and return to IDLE, no done
//   dn_we/dn_dim/dn_bit/dn_data  direction-number write v[dim][bit] (IDLE only)
//   out_valid/out_ready    point handshake
//   out_data, out_idx      FP16 coordinates (dim d at [16d+15:16d]) and point index
//   busy                   high while running
//   done                   one-cycle pulse after the last handshake
module sobol_multi_gen
    import sobol_pkg::*;
#(
    parameter int DIMS  = 4,
    parameter int BITS  = 16,
    parameter int IDX_W = 16,
    localparam int DW   = (DIMS > 1) ? $clog2(DIMS) : 1,
    localparam int CW   = $clog2(BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     num_points,
    input  logic                 abort,
    input  logic                 dn_we,
    input  logic [DW-1:0]        dn_dim,
    input  logic [CW-1:0]        dn_bit,
    input  logic [BITS-1:0]      dn_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*DIMS-1:0]   out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 busy,
    output logic                 done
);

    sobol_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] npts_q;
    logic [BITS-1:0]  x_q    [DIMS];
    logic [BITS-1:0]  x_next [DIMS];
    logic [BITS-1:0]  v_q    [DIMS][BITS];
    logic [16*DIMS-1:0] out_data_q;
    logic [16*DIMS-1:0] fp_next;
    logic [IDX_W-1:0] out_idx_q;
    logic [CW-1:0]    c;
    logic             c_found;
    logic             hs;
    logic             last_pt;
    logic             start_ok;

    // In RUN a point is always pending, so valid is simply the state.
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

    assign hs       = (state_q == RUN) && out_ready && !abort;
    assign last_pt  = (idx_q == npts_q - 1'b1);
    assign start_ok = (state_q == IDLE) && start;

    // Index of the lowest zero bit of i selects the direction number to fold in.
    // idx never reaches all-ones while a handshake is still pending, so the
    // fallback of 0 is never used to update x.
    always_comb begin
        c       = '0;
        c_found = 1'b0;
        for (int k = 0; k < IDX_W; k++) begin
            if (!idx_q[k] && !c_found) begin
                c       = CW'(k);
                c_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < DIMS; d++) begin
            x_next[d] = x_q[d] ^ v_q[d][c];
        end
    end

    // Conversion runs on the next x so the FP16 result lands in out_data
    // on the same edge that advances the index.
    for (genvar gd = 0; gd < DIMS; gd++) begin : g_conv
        ufix_to_fp16 #(.BITS(BITS)) u_conv (
            .x  (x_next[gd]),
            .fp (fp_next[16*gd +: 16])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_points == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready && last_pt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            npts_q     <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            for (int d = 0; d < DIMS; d++) begin
                x_q[d] <= '0;
            end
        end else if (start_ok) begin
            idx_q      <= '0;
            npts_q     <= num_points;
            out_idx_q  <= '0;
            out_data_q <= {DIMS{FP16_ZERO}};
            for (int d = 0; d < DIMS; d++) begin
                x_q[d] <= '0;
            end
        end else if (hs) begin
            idx_q      <= idx_q + 1'b1;
            out_idx_q  <= idx_q + 1'b1;
            out_data_q <= fp_next;
            for (int d = 0; d < DIMS; d++) begin
                x_q[d] <= x_next[d];
            end
        end
    end

    // Direction table. A write in the same IDLE cycle as start commits on this
    // edge, before the first handshake of the run can read it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DIMS; d++) begin
                for (int k = 0; k < BITS; k++) begin
                    v_q[d][k] <= BITS'(1) << (BITS - 1 - k);
                end
            end
        end else if ((state_q == IDLE) && dn_we
                     && (int'(dn_dim) < DIMS) && (int'(dn_bit) < BITS)) begin
            v_q[dn_dim][dn_bit] <= dn_data;
        end
    end

endmodule
